cascade_counter: RTL and testbench
==================================

# cascade_counter

Parametrised chain of STAGES up/down counters with individual moduli, e.g. a mm:ss digit chain in the alarm clock's timekeeping and alarm-set paths. Each stage counts 0..its maximum value and passes a carry or borrow to the next stage. On top of plain mod-N up/down counting, the block provides:
- a selectable entry stage, with or without cascading;
- wrap or saturate mode;
- per-stage masked load with range clamping;
- registered chain carry/borrow pulses.

## Interface
- STAGES, 4, number of cascaded stages; stage 0 is least significant.
- WIDTH, 4, bits per stage.
- MAXV, 16'h5959, packed maximum values; stage i max = MAXV[i*WIDTH +: WIDTH]; each max must be ≥ 1.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable (tick); has no effect on load.
- up  input  1  count up request.
- down  input  1  count down request.
- stage_sel  input  $clog2(STAGES)  stage that receives the tick.
- chain  input  1  1: carry/borrow propagates from stage_sel upward; 0: stage_sel wraps alone and higher stages are untouched.
- sat  input  1  0: wrap mode; 1: saturate mode.
- load  input  1  synchronous load strobe.
- load_mask  input  STAGES  stages written on load.
- data  input  STAGES*WIDTH  load value, packed like count.
- count  output  STAGES*WIDTH  packed stage values; reset value 0.
- carry_out  output  1  registered one-cycle pulse on a top-stage up wrap; reset value 0.
- borrow_out  output  1  registered one-cycle pulse on a top-stage down wrap; reset value 0.
- at_max  output  1  combinational; high when every stage equals its max.
- at_zero  output  1  combinational; high when every stage equals 0.

## Operation
- Priority, highest first: reset, then load, then count, then hold.
- Load: each stage i with load_mask[i]=1 takes data digit i. If the digit exceeds that stage's max, the stage takes its max (clamp). Unmasked stages hold. No count occurs in a load cycle. carry_out and borrow_out are 0 after a load cycle.
- A count step happens only when all of the following hold: en=1, up XOR down, and stage_sel < STAGES. Otherwise there is no step: up=down=1 holds, and an out-of-range stage_sel holds.
- Up step, chain=1: stage_sel increments. Any stage at its max goes to 0 and passes the carry to the next stage. Propagation stops at the first stage that is not at its max, or after the top stage.
- Down step, chain=1: stage_sel decrements. Any stage at 0 goes to its max and passes the borrow to the next stage. Propagation stops likewise.
- Stages below stage_sel never change on a step.
- chain=0: only stage_sel changes; it wraps max→0 (up) or 0→max (down). No propagation.
- Group for saturation: stages stage_sel..STAGES-1 when chain=1; stage_sel alone when chain=0.
- Saturate mode (sat=1):
  - Up step with every stage in the group at its max: hold, no carry.
  - Down step with every stage in the group at 0: hold, no borrow.
  - Otherwise the step behaves exactly as in wrap mode.
- carry_out: set to 1 on the edge where the top stage wraps max→0 through an up carry chain (chain=1) or a direct tick (stage_sel = STAGES-1). Otherwise cleared to 0.
- borrow_out: same rule, for a down step wrapping 0→max.
- No arithmetic overflow beyond WIDTH bits: every stage value stays within 0..max at all times after reset or load.

## Timing
- count update latency: 1 clock from the inputs sampled at the rising edge.
- carry_out and borrow_out are registered on the same edge as the wrapping count update. Each is high for exactly the one cycle in which the wrapped count is first visible.
- Back-to-back wraps produce back-to-back pulses.
- at_max and at_zero follow count combinationally with no added latency.
- Reset asserted mid-operation immediately forces count=0, carry_out=0, borrow_out=0. After reset deasserts, the first count happens on the first rising edge with a valid step.
- All control inputs are sampled only at the rising edge; there is no handshake.

## Test plan
- Reset mid-count: count 16'h3427, assert reset between edges → count=0, at_zero=1, carry_out=0 immediately.
- Up wrap: load 16'h5958 (mask 4'b1111); then en=1, up=1, stage_sel=0, chain=1, sat=0 for 2 cycles → 16'h5959 (at_max=1), then 16'h0000 with carry_out high for exactly that one cycle.
- Down wrap: from 16'h0000, en=1, down=1, stage_sel=0, chain=1 → 16'h5959 with one-cycle borrow_out.
- Entry stage and chain:
  - From 16'h1959, stage_sel=2, up, chain=0 → 16'h1059; stage 3 unchanged, no carry.
  - From the same state with chain=1 → 16'h2059.
- Saturate and no-step cases:
  - From 16'h5959, sat=1, up, stage_sel=0, chain=1 → holds 16'h5959, carry_out=0.
  - up=down=1 → holds.
  - en=0 → holds.
- Masked load with clamp:
  - From 16'h0000, load_mask=4'b0001, data 16'h000C → 16'h0009.
  - load_mask=4'b1111, data 16'hFA7C → 16'h5959.
  - load asserted together with up → load wins, no step.

Source files
------------

// File: rtl/cascade_counter.sv
// Cascaded mod-N up/down counter chain (e.g. mm:ss digits).
// Selectable entry stage, wrap/saturate, clamped masked load.
module cascade_counter #(
    parameter int STAGES = 4,
    parameter int WIDTH = 4,
    parameter logic [STAGES*WIDTH-1:0] MAXV = 16'h5959
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic up,
    input  logic down,
    input  logic [$clog2(STAGES)-1:0] stage_sel,
    input  logic chain,
    input  logic sat,
    input  logic load,
    input  logic [STAGES-1:0] load_mask,
    input  logic [STAGES*WIDTH-1:0] data,
    output logic [STAGES*WIDTH-1:0] count,
    output logic carry_out,
    output logic borrow_out,
    output logic at_max,
    output logic at_zero
);

    logic [STAGES*WIDTH-1:0] count_d;
    logic carry_d;
    logic borrow_d;
    logic sel_ok;
    logic grp_max;
    logic grp_zero;
    logic step;
    logic cy;
    logic [WIDTH-1:0] dig;
    logic [WIDTH-1:0] mx;

    assign sel_ok = int'(stage_sel) < STAGES;

    // Saturation group: entry stage, plus everything above it when chained
    always_comb begin
        grp_max = 1'b1;
        grp_zero = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (i == int'(stage_sel) || (chain && i > int'(stage_sel))) begin
                if (count[i*WIDTH +: WIDTH] != MAXV[i*WIDTH +: WIDTH])
                    grp_max = 1'b0;
                if (count[i*WIDTH +: WIDTH] != '0)
                    grp_zero = 1'b0;
            end
        end
    end

    assign step = en & (up ^ down) & sel_ok
                & ~(sat & (up ? grp_max : grp_zero));

    // Next count: clamped masked load, else ripple step from entry stage
    always_comb begin
        count_d = count;
        carry_d = 1'b0;
        borrow_d = 1'b0;
        cy = 1'b0;
        dig = '0;
        mx = '0;
        if (load) begin
            for (int i = 0; i < STAGES; i++) begin
                dig = data[i*WIDTH +: WIDTH];
                mx = MAXV[i*WIDTH +: WIDTH];
                if (load_mask[i])
                    count_d[i*WIDTH +: WIDTH] = (dig > mx) ? mx : dig;
            end
        end else if (step) begin
            for (int i = 0; i < STAGES; i++) begin
                dig = count[i*WIDTH +: WIDTH];
                mx = MAXV[i*WIDTH +: WIDTH];
                if (i == int'(stage_sel))
                    cy = 1'b1;
                else if (!chain)
                    cy = 1'b0;
                if (cy) begin
                    if (up) begin
                        if (dig == mx) begin
                            count_d[i*WIDTH +: WIDTH] = '0;
                        end else begin
                            count_d[i*WIDTH +: WIDTH] = dig + 1'b1;
                            cy = 1'b0;
                        end
                    end else begin
                        if (dig == '0) begin
                            count_d[i*WIDTH +: WIDTH] = mx;
                        end else begin
                            count_d[i*WIDTH +: WIDTH] = dig - 1'b1;
                            cy = 1'b0;
                        end
                    end
                end
            end
            // cy still set here means the top stage wrapped
            carry_d = cy & up;
            borrow_d = cy & down;
        end
    end

    // State and wrap-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            carry_out <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            count <= count_d;
            carry_out <= carry_d;
            borrow_out <= borrow_d;
        end
    end

    assign at_max = (count == MAXV);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter.
// Reference model treats the active group as one mixed-radix number.
module tb_cascade_counter;

    localparam logic [15:0] MX = 16'h5959;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic up;
    logic down;
    logic [1:0] stage_sel;
    logic chain;
    logic sat;
    logic load;
    logic [3:0] load_mask;
    logic [15:0] data;
    logic [15:0] count;
    logic carry_out;
    logic borrow_out;
    logic at_max;
    logic at_zero;

    typedef struct packed {
        logic [15:0] c;
        logic co;
        logic bo;
    } exp_t;

    exp_t sb[$];
    logic [15:0] m_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cascade_counter #(
        .STAGES(4),
        .WIDTH(4),
        .MAXV(16'h5959)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .up(up),
        .down(down),
        .stage_sel(stage_sel),
        .chain(chain),
        .sat(sat),
        .load(load),
        .load_mask(load_mask),
        .data(data),
        .count(count),
        .carry_out(carry_out),
        .borrow_out(borrow_out),
        .at_max(at_max),
        .at_zero(at_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int mx(input int i);
        logic [15:0] t;
        t = MX;
        return int'(t[i*4 +: 4]);
    endfunction

    function automatic int digit(input logic [15:0] v, input int i);
        return int'(v[i*4 +: 4]);
    endfunction

    // Compute next expected state from current inputs and push it
    task automatic predict();
        exp_t e;
        int lo;
        int hi;
        int d;
        longint v;
        longint tot;
        logic [15:0] n;
        n = m_cnt;
        e.co = 1'b0;
        e.bo = 1'b0;
        if (load) begin
            for (int i = 0; i < 4; i++) begin
                d = digit(data, i);
                if (load_mask[i])
                    n[i*4 +: 4] = 4'((d > mx(i)) ? mx(i) : d);
            end
        end else if (en && (up != down)) begin
            lo = int'(stage_sel);
            hi = chain ? 3 : lo;
            v = 0;
            tot = 1;
            for (int i = hi; i >= lo; i--) begin
                v = v * (mx(i) + 1) + digit(m_cnt, i);
                tot = tot * (mx(i) + 1);
            end
            if (up) begin
                if (!(sat && v == tot - 1)) begin
                    v++;
                    if (v == tot) begin
                        v = 0;
                        e.co = (hi == 3);
                    end
                end
            end else begin
                if (!(sat && v == 0)) begin
                    if (v == 0) begin
                        v = tot - 1;
                        e.bo = (hi == 3);
                    end else begin
                        v--;
                    end
                end
            end
            for (int i = lo; i <= hi; i++) begin
                n[i*4 +: 4] = 4'(v % (mx(i) + 1));
                v = v / (mx(i) + 1);
            end
        end
        e.c = n;
        m_cnt = n;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("count", count, e.c);
            chk("carry", carry_out, e.co);
            chk("borrow", borrow_out, e.bo);
            chk("at_max", at_max, e.c == MX);
            chk("at_zero", at_zero, e.c == 16'h0);
        end
    endtask

    task automatic drv(input logic e_, input logic u_, input logic d_,
                       input logic [1:0] s_, input logic ch_,
                       input logic sa_);
        en = e_;
        up = u_;
        down = d_;
        stage_sel = s_;
        chain = ch_;
        sat = sa_;
        load = 1'b0;
        cyc();
    endtask

    task automatic ld(input logic [3:0] m_, input logic [15:0] d_);
        en = 1'b0;
        up = 1'b0;
        down = 1'b0;
        load = 1'b1;
        load_mask = m_;
        data = d_;
        cyc();
        load = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        en = 1'b0;
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_count"}, count, 16'h0);
        chk({tag, "_zero"}, at_zero, 1'b1);
        chk({tag, "_carry"}, carry_out, 1'b0);
        chk({tag, "_borrow"}, borrow_out, 1'b0);
        m_cnt = '0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        up = 1'b0;
        down = 1'b0;
        stage_sel = 2'd0;
        chain = 1'b1;
        sat = 1'b0;
        load = 1'b0;
        load_mask = 4'h0;
        data = 16'h0;
        m_cnt = 16'h0;
        #12;
        chk("rst_count", count, 16'h0);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_borrow", borrow_out, 1'b0);
        chk("rst_zero", at_zero, 1'b1);
        chk("rst_max", at_max, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        ld(4'hF, 16'h5958);
        drv(1, 1, 0, 2'd0, 1, 0);
        chk("upwrap_max", count, 16'h5959);
        drv(1, 1, 0, 2'd0, 1, 0);
        chk("upwrap_zero", count, 16'h0000);
        chk("upwrap_pulse", carry_out, 1'b1);
        drv(0, 0, 0, 2'd0, 1, 0);
        chk("upwrap_once", carry_out, 1'b0);

        drv(1, 0, 1, 2'd0, 1, 0);
        chk("dnwrap", count, 16'h5959);
        chk("dnwrap_pulse", borrow_out, 1'b1);
        drv(0, 0, 0, 2'd0, 1, 0);

        ld(4'hF, 16'h1959);
        drv(1, 1, 0, 2'd2, 0, 0);
        chk("nochain", count, 16'h1059);
        ld(4'hF, 16'h1959);
        drv(1, 1, 0, 2'd2, 1, 0);
        chk("chain", count, 16'h2059);

        ld(4'hF, 16'h5959);
        drv(1, 1, 0, 2'd0, 1, 1);
        chk("sat_hold", count, 16'h5959);
        drv(1, 1, 1, 2'd0, 1, 0);
        drv(0, 1, 0, 2'd0, 1, 0);
        chk("en0_hold", count, 16'h5959);

        drv(1, 1, 0, 2'd3, 0, 0);
        drv(1, 0, 1, 2'd3, 0, 0);
        drv(1, 1, 0, 2'd3, 0, 0);
        chk("b2b", count, 16'h0959);
        drv(1, 0, 1, 2'd1, 0, 1);
        drv(1, 0, 1, 2'd3, 1, 1);

        ld(4'hF, 16'h0000);
        ld(4'h1, 16'h000C);
        chk("clamp1", count, 16'h0009);
        ld(4'hF, 16'hFA7C);
        chk("clamp4", count, 16'h5959);
        en = 1'b1;
        up = 1'b1;
        load = 1'b1;
        load_mask = 4'hF;
        data = 16'h1234;
        cyc();
        load = 1'b0;
        chk("load_wins", count, 16'h1234);

        ld(4'hF, 16'h3427);
        drv(1, 1, 0, 2'd0, 1, 0);
        mid_reset("rst_mid");
        ld(4'hF, 16'h5959);
        en = 1'b1;
        up = 1'b1;
        down = 1'b0;
        stage_sel = 2'd0;
        chain = 1'b1;
        sat = 1'b0;
        predict();
        @(posedge clk);
        sb.delete();
        mid_reset("rst_pulse");

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                ld(4'($urandom), 16'($urandom));
            end else begin
                drv(1'($urandom_range(0, 7) != 0), 1'($urandom),
                    1'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
